stepper_move_ctrl: RTL and testbench
====================================

// Module: stepper_move_ctrl
// PURPOSE
// Next-generation 4-coil unipolar stepper controller (PMOD step driver class).
// Accepts move commands of N steps over a valid/ready handshake, with runtime step period and full/half-step mode.
// Tracks absolute signed position and supports abort and optional holding torque.
// Sits between game/FSM logic and the PMOD coil pins; replaces free-running dir/en driving.
// PARAMETERS
// DIV_W      26      width of step-period counter and period input
// CNT_W      16      width of step-count command
// POS_W      24      width of signed absolute position counter
// HOLD_EN    0       1: coils stay energised at last phase when idle; 0: coils = 4'b0000 when idle
// PORTS
// clk          in   1      system clock
// rst          in   1      reset, asynchronous, active-high
// cmd_valid    in   1      move command present
// cmd_ready    out  1      controller can accept command (high only in IDLE)
// cmd_dir      in   1      0 = forward (phase index +), 1 = reverse (phase index -)
// cmd_steps    in   CNT_W  number of steps to execute
// cmd_half     in   1      1 = half-step, 0 = full-step
// cmd_period   in   DIV_W  clk cycles per step; 0 treated as 1
// abort        in   1      stop current move before next step
// busy         out  1      high in RUN
// done         out  1      one-cycle pulse at end of every accepted command
// aborted      out  1      valid with done: 1 if move ended by abort
// pos          out  POS_W  signed absolute position in steps
// coil         out  4      coil drive, registered
// BEHAVIOUR
// - Reset: state=IDLE, phase idx=0, pos=0, remaining=0, period ctr=0, cmd_ready=1, busy=0, done=0, aborted=0, coil=0000 (HOLD_EN=0) or 0001 (HOLD_EN=1).
// - States: IDLE -> RUN (accept, steps>0) | DONE (accept, steps=0); RUN -> DONE (remaining hits 0 or abort); DONE -> IDLE after 1 cycle.
// - Accept = cmd_valid & cmd_ready on a rising edge; dir, steps, half and max(period,1) latched; later input changes ignored.
// - Phase table idx0..7: 0001,0011,0010,0110,0100,1100,1000,1001; idx is 3-bit and wraps mod 8.
// - Step increment: half=1 -> +/-1, half=0 -> +/-2; odd idx stays odd in full-step mode (two-coil drive).
// - Period ctr clears on accept, counts in RUN; at count == period-1 a step fires and ctr returns to 0.
// - First step fires `period` cycles after the accept edge; then one step every `period` cycles.
// - On a step edge: idx updates, coil=table[new idx], pos +/-1 (+ forward, - reverse; +1 per step even in full mode), remaining-1.
// - Remaining reaching 0 on a step edge -> DONE next cycle: done=1, aborted=0 for that cycle.
// - abort in RUN has priority over a step in the same cycle: no step, -> DONE with aborted=1; abort ignored in IDLE/DONE.
// - steps=0 command: no coil change, done pulse in the cycle after accept, aborted=0.
// - pos wraps in two's complement at POS_W limits, no saturation.
// - Coil in IDLE/DONE: table[idx] if HOLD_EN=1, else 0000; in RUN always table[idx].
// - cmd_ready=0 in RUN and DONE; back-to-back commands possible: earliest next accept 1 cycle after done.
// - Async rst mid-move: all state back to reset values immediately; move lost, no done pulse.
// TESTING
// - Fwd half, steps=3, period=4 from reset: coils 0011,0010,0110 at cycles 4,8,12 after accept; pos=3; done at cycle 13.
// - Rev full, steps=2, period=1, idx=0: coil 1000 then 0100; pos=-2; done=1, aborted=0 next cycle.
// - steps=0, period=5: no coil activity, done in cycle after accept, pos unchanged.
// - steps=100, period=10, abort asserted on a step-fire cycle after 5 steps: pos=5, no 6th step, done=1 and aborted=1.
// - pos at 2^(POS_W-1)-1, 1 fwd step -> pos = -2^(POS_W-1); idx 7 + half fwd step -> idx 0, coil 0001.
// - HOLD_EN=0 vs 1 after a move: coil 0000 vs last phase; rst asserted mid-move -> coil reset value, cmd_ready=1, pos=0, no done.

Source files
------------

// File: rtl/stepper_move_ctrl.sv
// stepper_move_ctrl
// Move-command controller for a 4-coil unipolar stepper (PMOD step driver).
// A command (direction, step count, half/full mode, step period) is taken
// over a valid/ready handshake. The controller then walks the 8-entry phase
// table at one step per period and tracks a signed absolute step position.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   cmd_valid/ready handshake; ready is high only while idle
//   cmd_dir         0 = forward (phase index +), 1 = reverse (phase index -)
//   cmd_steps       number of steps in the move
//   cmd_half        1 = half-step, 0 = full-step
//   cmd_period      clk cycles per step (0 behaves as 1)
//   abort           ends a running move before its next step
//   busy            high while a move is running
//   done, aborted   one-cycle completion pulse; aborted qualifies done
//   pos             signed absolute position in steps
//   coil            registered coil drive
module stepper_move_ctrl #(
    parameter int DIV_W   = 26,
    parameter int CNT_W   = 16,
    parameter int POS_W   = 24,
    parameter bit HOLD_EN = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_dir,
    input  logic [CNT_W-1:0]        cmd_steps,
    input  logic                    cmd_half,
    input  logic [DIV_W-1:0]        cmd_period,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic signed [POS_W-1:0] pos,
    output logic [3:0]              coil
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic signed [POS_W-1:0] POS_ONE   = POS_W'(1);
    localparam logic [DIV_W-1:0]        PERIOD_MIN = DIV_W'(1);

    state_t                    state;
    logic [2:0]                idx;
    logic [CNT_W-1:0]          remaining;
    logic [DIV_W-1:0]          period_r;
    logic [DIV_W-1:0]          ctr;
    logic                      dir_r;
    logic                      half_r;

    logic [2:0]                step_sz;
    logic [2:0]                idx_step;
    logic signed [POS_W-1:0]   pos_step;
    logic                      step_fire;
    logic [3:0]                idle_coil;

    function automatic logic [3:0] phase(input logic [2:0] i);
        logic [3:0] p;
        case (i)
            3'd0:    p = 4'b0001;
            3'd1:    p = 4'b0011;
            3'd2:    p = 4'b0010;
            3'd3:    p = 4'b0110;
            3'd4:    p = 4'b0100;
            3'd5:    p = 4'b1100;
            3'd6:    p = 4'b1000;
            default: p = 4'b1001;
        endcase
        return p;
    endfunction

    // Full-step moves by 2 so an odd index stays odd (two-coil drive).
    // The 3-bit index wraps naturally mod 8.
    assign step_sz   = half_r ? 3'd1 : 3'd2;
    assign idx_step  = dir_r ? (idx - step_sz) : (idx + step_sz);
    // Position counts steps, not phase positions: +/-1 even in full-step.
    assign pos_step  = dir_r ? (pos - POS_ONE) : (pos + POS_ONE);
    assign step_fire = (ctr == (period_r - PERIOD_MIN));
    assign idle_coil = HOLD_EN ? phase(idx) : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 3'd0;
            pos       <= '0;
            remaining <= '0;
            period_r  <= '0;
            ctr       <= '0;
            dir_r     <= 1'b0;
            half_r    <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            coil      <= HOLD_EN ? 4'b0001 : 4'b0000;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        dir_r     <= cmd_dir;
                        half_r    <= cmd_half;
                        period_r  <= (cmd_period == '0) ? PERIOD_MIN : cmd_period;
                        remaining <= cmd_steps;
                        ctr       <= '0;
                        cmd_ready <= 1'b0;
                        if (cmd_steps == '0) begin
                            // Empty move: straight to the completion pulse.
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            coil  <= phase(idx);
                        end
                    end
                end
                RUN: begin
                    // The last step is left visible on the coils for one
                    // cycle before the move is closed out.
                    if (remaining == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        coil  <= idle_coil;
                    end else if (abort) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                        coil    <= idle_coil;
                    end else if (step_fire) begin
                        ctr       <= '0;
                        idx       <= idx_step;
                        coil      <= phase(idx_step);
                        pos       <= pos_step;
                        remaining <= remaining - 1'b1;
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// tb_stepper_move_ctrl
// Directed bench for stepper_move_ctrl. Two instances share all inputs:
// dut0 (8-bit position, no holding torque) and dut1 (default 24-bit
// position, holding torque). A command table drives back-to-back moves;
// hand-written sequences cover cycle timing, abort, reset mid-move and
// position wrap.
module tb_stepper_move_ctrl;

    logic               clk;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_dir;
    logic [15:0]        cmd_steps;
    logic               cmd_half;
    logic [25:0]        cmd_period;
    logic               abort;

    logic               rdy0, busy0, done0, ab0;
    logic signed [7:0]  pos0;
    logic [3:0]         coil0;
    logic               rdy1, busy1, done1, ab1;
    logic signed [23:0] pos1;
    logic [3:0]         coil1;

    int n_vec  = 0;
    int n_fail = 0;

    stepper_move_ctrl #(.DIV_W(26), .CNT_W(16), .POS_W(8), .HOLD_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_half(cmd_half),
        .cmd_period(cmd_period), .abort(abort), .busy(busy0), .done(done0),
        .aborted(ab0), .pos(pos0), .coil(coil0)
    );

    stepper_move_ctrl #(.DIV_W(26), .CNT_W(16), .POS_W(24), .HOLD_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_half(cmd_half),
        .cmd_period(cmd_period), .abort(abort), .busy(busy1), .done(done1),
        .aborted(ab1), .pos(pos1), .coil(coil1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       dir;
        int         steps;
        logic       half;
        int         period;
        int         lat;    // ticks after the accept edge until done is seen
        int         pos;    // absolute position after the move
        logic [3:0] hold;   // coil of the holding instance after the move
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Presents a command for exactly one edge, then scrambles the command
    // inputs so any late sampling by the DUT would show up.
    task automatic issue(input logic d, input int s, input logic h, input int p);
        chk("ready_before_accept", rdy0, 1);
        cmd_valid  = 1'b1;
        cmd_dir    = d;
        cmd_steps  = 16'(s);
        cmd_half   = h;
        cmd_period = 26'(p);
        tick();
        cmd_valid  = 1'b0;
        cmd_dir    = ~d;
        cmd_steps  = 16'hffff;
        cmd_half   = ~h;
        cmd_period = 26'd3;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done0 && lat < 3000) begin
            tick();
            lat++;
        end
    endtask

    task automatic pulse_rst();
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int lat;
        int npulse;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_steps  = '0;
        cmd_half   = 1'b0;
        cmd_period = '0;
        abort      = 1'b0;

        // Table starts from idx 4, pos -2 (state left by the reverse test).
        tbl[0] = '{1'b0, 0, 1'b1, 5, 0, -2, 4'b0100};
        tbl[1] = '{1'b0, 3, 1'b0, 2, 7,  1, 4'b0010};
        tbl[2] = '{1'b1, 5, 1'b1, 0, 6, -4, 4'b1100};
        tbl[3] = '{1'b0, 4, 1'b1, 3, 13, 0, 4'b0011};
        tbl[4] = '{1'b1, 1, 1'b0, 1, 2, -1, 4'b1001};
        tbl[5] = '{1'b0, 2, 1'b0, 1, 3,  1, 4'b0110};
        tbl[6] = '{1'b1, 0, 1'b0, 0, 0,  1, 4'b0110};

        #17 rst = 1'b0;
        tick();

        chk("rst_ready",   rdy0,  1);
        chk("rst_busy",    busy0, 0);
        chk("rst_done",    done0, 0);
        chk("rst_aborted", ab0,   0);
        chk("rst_pos",     pos0,  0);
        chk("rst_coil0",   coil0, 4'b0000);
        chk("rst_coil1",   coil1, 4'b0001);
        chk("rst_pos1",    pos1,  0);

        // Forward half-step, 3 steps, period 4, from reset.
        issue(1'b0, 3, 1'b1, 4);
        repeat (3) tick();
        chk("h1_coil_run_idx0", coil0, 4'b0001);
        chk("h1_busy",  busy0, 1);
        chk("h1_ready", rdy0,  0);
        tick();
        chk("h1_coil_s1", coil0, 4'b0011);
        chk("h1_pos_s1",  pos0,  1);
        repeat (4) tick();
        chk("h1_coil_s2", coil0, 4'b0010);
        repeat (4) tick();
        chk("h1_coil_s3", coil0, 4'b0110);
        chk("h1_pos_s3",  pos0,  3);
        chk("h1_done_early", done0, 0);
        tick();
        chk("h1_done",    done0, 1);
        chk("h1_aborted", ab0,   0);
        chk("h1_coil0_idle", coil0, 4'b0000);
        chk("h1_coil1_hold", coil1, 4'b0110);
        chk("h1_pos1",    pos1,  3);
        tick();
        chk("h1_ready_after", rdy0,  1);
        chk("h1_done_clear",  done0, 0);

        // Reverse full-step, 2 steps, period 1, from idx 0.
        pulse_rst();
        chk("rst2_pos", pos0, 0);
        chk("rst2_coil1", coil1, 4'b0001);
        issue(1'b1, 2, 1'b0, 1);
        tick();
        chk("h2_coil_s1", coil0, 4'b1000);
        chk("h2_pos_s1",  pos0,  -1);
        tick();
        chk("h2_coil_s2", coil0, 4'b0100);
        chk("h2_pos_s2",  pos0,  -2);
        chk("h2_done_early", done0, 0);
        tick();
        chk("h2_done",    done0, 1);
        chk("h2_aborted", ab0,   0);
        chk("h2_pos1",    pos1,  -2);
        tick();

        // Back-to-back command table.
        for (int i = 0; i < 7; i++) begin
            issue(tbl[i].dir, tbl[i].steps, tbl[i].half, tbl[i].period);
            wait_done(lat);
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_pos0", i), pos0, tbl[i].pos);
            chk($sformatf("tbl%0d_pos1", i), pos1, tbl[i].pos);
            chk($sformatf("tbl%0d_aborted", i), ab0, 0);
            chk($sformatf("tbl%0d_busy", i), busy0, 0);
            chk($sformatf("tbl%0d_coil0", i), coil0, 4'b0000);
            chk($sformatf("tbl%0d_coil1", i), coil1, tbl[i].hold);
            tick();
            chk($sformatf("tbl%0d_ready", i), rdy0, 1);
        end

        // Abort after 5 steps, asserted on the cycle the 6th step would fire.
        pulse_rst();
        issue(1'b0, 100, 1'b1, 10);
        repeat (49) tick();
        chk("ab_pos_s4", pos0, 4);
        chk("ab_coil_s4", coil0, 4'b0100);
        tick();
        chk("ab_pos_s5", pos0, 5);
        chk("ab_coil_s5", coil0, 4'b1100);
        repeat (9) tick();
        chk("ab_busy_pre", busy0, 1);
        abort = 1'b1;
        tick();
        chk("ab_done",    done0, 1);
        chk("ab_aborted", ab0,   1);
        chk("ab_pos",     pos0,  5);
        chk("ab_coil0",   coil0, 4'b0000);
        chk("ab_coil1",   coil1, 4'b1100);
        tick();
        chk("ab_ready",        rdy0,  1);
        chk("ab_aborted_clr",  ab0,   0);
        tick();
        chk("ab_idle_busy", busy0, 0);
        chk("ab_idle_done", done0, 0);
        abort = 1'b0;

        // Asynchronous reset in the middle of a move.
        issue(1'b0, 10, 1'b1, 2);
        repeat (5) tick();
        chk("mr_pos_before", pos0, 7);
        chk("mr_coil_before", coil0, 4'b1001);
        #2 rst = 1'b1;
        #1;
        chk("mr_ready", rdy0,  1);
        chk("mr_busy",  busy0, 0);
        chk("mr_pos0",  pos0,  0);
        chk("mr_pos1",  pos1,  0);
        chk("mr_coil0", coil0, 4'b0000);
        chk("mr_coil1", coil1, 4'b0001);
        chk("mr_done",  done0, 0);
        tick();
        rst = 1'b0;
        npulse = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done0 || busy0) npulse++;
        end
        chk("mr_no_done_after", npulse, 0);

        // Position wrap on the 8-bit instance; phase index 7 -> 0.
        issue(1'b0, 127, 1'b1, 1);
        wait_done(lat);
        chk("wr_latency", lat, 128);
        chk("wr_pos0_max", pos0, 127);
        chk("wr_pos1", pos1, 127);
        chk("wr_coil1_idx7", coil1, 4'b1001);
        tick();
        issue(1'b0, 1, 1'b1, 1);
        tick();
        chk("wr_coil_idx0", coil0, 4'b0001);
        chk("wr_pos0_wrap", pos0, -128);
        chk("wr_pos1_nowrap", pos1, 128);
        tick();
        chk("wr_done", done0, 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

endmodule
